// File: rtl/cbc_chain_if.sv
// ---------------------------------------------------------------------------
// cbc_chain_if
// Stream bundle for cbc_chain.
//   s_axis_*     : plaintext stream into cbc_chain
//   m_axis_*     : ciphertext stream out of cbc_chain
//   enc_m_axis_* : block from cbc_chain to the encryption core input
//   enc_s_axis_* : result from the encryption core output to cbc_chain
// Modports:
//   slave  : the cbc_chain side
//   master : the environment side (source, sink and encryption core)
// ---------------------------------------------------------------------------
interface cbc_chain_if;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;

    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    logic [63:0] enc_m_axis_tdata;
    logic        enc_m_axis_tvalid;
    logic        enc_m_axis_tready;

    logic [63:0] enc_s_axis_tdata;
    logic        enc_s_axis_tvalid;
    logic        enc_s_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output enc_m_axis_tdata, enc_m_axis_tvalid,
        input  enc_m_axis_tready,
        input  enc_s_axis_tdata, enc_s_axis_tvalid,
        output enc_s_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  enc_m_axis_tdata, enc_m_axis_tvalid,
        output enc_m_axis_tready,
        output enc_s_axis_tdata, enc_s_axis_tvalid,
        input  enc_s_axis_tready
    );
endinterface

// File: rtl/cbc_chain.sv
// ---------------------------------------------------------------------------
// cbc_chain
// CBC-mode chaining around an external block-encryption core:
//   C[i] = E(P[i] xor chain), chain <= C[i], one block in flight at a time.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   iv         64-bit initialisation vector
//   iv_load    one-cycle pulse, loads iv into the chaining register (ACCEPT only)
//   key_ready  round keys valid; gates acceptance of new plaintext
//   bus        cbc_chain_if.slave: plaintext in, ciphertext out, core in/out
//   blk_count  number of ciphertext blocks delivered (wraps)
// Build option:
//   CBC_TLAST_REIV_EN  when defined, delivering a block with tlast reloads
//                      chain from iv so each message restarts from the IV.
// ---------------------------------------------------------------------------
module cbc_chain (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] iv,
    input  logic        iv_load,
    input  logic        key_ready,
    cbc_chain_if.slave  bus,
    output logic [31:0] blk_count
);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t      r_state;
    logic [63:0] r_chain;
    logic [63:0] r_blk;
    logic [63:0] r_out;
    logic        r_last;
    logic [31:0] r_blk_count;
    // Low while in reset and for the first edge after it, so s_axis_tready
    // cannot follow key_ready while reset is asserted.
    logic        r_run;

    logic        w_s_hs;
    logic        w_enc_m_hs;
    logic        w_enc_s_hs;
    logic        w_m_hs;
    logic [63:0] w_chain_src;

    assign bus.s_axis_tready     = r_run & (r_state == ACCEPT) & key_ready;
    assign bus.enc_m_axis_tvalid = (r_state == SEND);
    assign bus.enc_m_axis_tdata  = r_blk;
    assign bus.enc_s_axis_tready = (r_state == WAIT);
    assign bus.m_axis_tvalid     = (r_state == OUT);
    assign bus.m_axis_tdata      = r_out;
    assign bus.m_axis_tlast      = r_last & (r_state == OUT);
    assign blk_count             = r_blk_count;

    assign w_s_hs     = bus.s_axis_tvalid & bus.s_axis_tready;
    assign w_enc_m_hs = bus.enc_m_axis_tvalid & bus.enc_m_axis_tready;
    assign w_enc_s_hs = bus.enc_s_axis_tvalid & bus.enc_s_axis_tready;
    assign w_m_hs     = bus.m_axis_tvalid & bus.m_axis_tready;

    // A coincident iv_load wins over the stored chain for the XOR.
    assign w_chain_src = iv_load ? iv : r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCEPT;
            r_chain     <= '0;
            r_blk       <= '0;
            r_out       <= '0;
            r_last      <= 1'b0;
            r_blk_count <= '0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ACCEPT: begin
                    if (iv_load) begin
                        r_chain <= iv;
                    end
                    if (w_s_hs) begin
                        r_blk   <= bus.s_axis_tdata ^ w_chain_src;
                        r_last  <= bus.s_axis_tlast;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_enc_m_hs) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_enc_s_hs) begin
                        r_chain <= bus.enc_s_axis_tdata;
                        r_out   <= bus.enc_s_axis_tdata;
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (w_m_hs) begin
                        r_blk_count <= r_blk_count + 32'd1;
                        r_state     <= ACCEPT;
`ifdef CBC_TLAST_REIV_EN
                        if (r_last) begin
                            r_chain <= iv;
                        end
`endif
                    end
                end
                default: r_state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_cbc_chain.sv
// ---------------------------------------------------------------------------
// tb_cbc_chain
// Directed bench for cbc_chain with a loopback encryption core that returns
// its input unchanged 3 cycles after accepting it.
// ---------------------------------------------------------------------------
module tb_cbc_chain;

    logic        clk;
    logic        rst;
    logic [63:0] iv;
    logic        iv_load;
    logic        key_ready;
    logic [31:0] blk_count;

    cbc_chain_if bus ();

    cbc_chain dut (
        .clk       (clk),
        .rst       (rst),
        .iv        (iv),
        .iv_load   (iv_load),
        .key_ready (key_ready),
        .bus       (bus),
        .blk_count (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback core stub
    logic        stub_busy;
    logic        stub_valid;
    logic [1:0]  stub_cnt;
    logic [63:0] stub_data;

    assign bus.enc_m_axis_tready = ~stub_busy;
    assign bus.enc_s_axis_tvalid = stub_valid;
    assign bus.enc_s_axis_tdata  = stub_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_busy  <= 1'b0;
            stub_valid <= 1'b0;
            stub_cnt   <= 2'd0;
            stub_data  <= '0;
        end else if (!stub_busy) begin
            if (bus.enc_m_axis_tvalid) begin
                stub_busy <= 1'b1;
                stub_data <= bus.enc_m_axis_tdata;
                stub_cnt  <= 2'd2;
            end
        end else if (!stub_valid) begin
            if (stub_cnt == 2'd0) stub_valid <= 1'b1;
            else                  stub_cnt   <= stub_cnt - 2'd1;
        end else if (bus.enc_s_axis_tready) begin
            stub_valid <= 1'b0;
            stub_busy  <= 1'b0;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; presents one plaintext block and returns at the
    // negedge after it was accepted.
    task automatic push(input logic [63:0] p, input logic l);
        int unsigned n;
        bus.s_axis_tdata  = p;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.s_axis_tready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.s_axis_tready) check_val("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
    endtask

    // Called at a negedge with m_axis_tready = 1; returns the ciphertext at
    // the negedge after its handshake.
    task automatic pull(output logic [63:0] c, output logic l);
        int unsigned n;
        n = 0;
        while (!bus.m_axis_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.m_axis_tvalid) check_val("output_timeout", 64'd0, 64'd1);
        c = bus.m_axis_tdata;
        l = bus.m_axis_tlast;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] c0, c1, c2, ref_c;
        logic        l0, l1;
        int unsigned bad;

        rst               = 1'b1;
        iv                = '0;
        iv_load           = 1'b0;
        key_ready         = 1'b1;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b1;

        // Reset state (key_ready high must not leak to s_axis_tready)
        @(negedge clk);
        check_val("rst_s_tready",   {63'd0, bus.s_axis_tready},     64'd0);
        check_val("rst_m_tvalid",   {63'd0, bus.m_axis_tvalid},     64'd0);
        check_val("rst_m_tlast",    {63'd0, bus.m_axis_tlast},      64'd0);
        check_val("rst_m_tdata",    bus.m_axis_tdata,               64'd0);
        check_val("rst_enc_tvalid", {63'd0, bus.enc_m_axis_tvalid}, 64'd0);
        check_val("rst_enc_tready", {63'd0, bus.enc_s_axis_tready}, 64'd0);
        check_val("rst_blk_count",  {32'd0, blk_count},             64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Key gate
        key_ready         = 1'b0;
        bus.s_axis_tdata  = 64'h1111_2222_3333_4444;
        bus.s_axis_tvalid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.s_axis_tready || bus.enc_m_axis_tvalid) bad++;
        end
        check_val("gate_hold", 64'(bad), 64'd0);
        key_ready = 1'b1;
        #1;
        check_val("gate_open", {63'd0, bus.s_axis_tready}, 64'd1);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        check_val("gate_send_valid", {63'd0, bus.enc_m_axis_tvalid}, 64'd1);
        check_val("gate_send_data",  bus.enc_m_axis_tdata, 64'h1111_2222_3333_4444);
        check_val("gate_send_noacc", {63'd0, bus.s_axis_tready}, 64'd0);
        pull(c0, l0);
        check_val("gate_c", c0, 64'h1111_2222_3333_4444);
        check_val("gate_count", {32'd0, blk_count}, 64'd1);

        // Chaining from an IV
        do_reset();
        iv      = 64'h0123_4567_89AB_CDEF;
        iv_load = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
        push(64'd0, 1'b0);
        pull(c0, l0);
        check_val("chain_c0", c0, 64'h0123_4567_89AB_CDEF);
        push(64'h0123_4567_89AB_CDEF, 1'b0);
        pull(c1, l1);
        check_val("chain_c1", c1, 64'd0);
        check_val("chain_count", {32'd0, blk_count}, 64'd2);

        // iv_load coincident with acceptance: XOR uses iv
        iv      = 64'hAAAA_AAAA_AAAA_AAAA;
        iv_load = 1'b1;
        push(64'h5555_5555_5555_5555, 1'b0);
        iv_load = 1'b0;
        pull(c0, l0);
        check_val("coinc_c", c0, 64'hFFFF_FFFF_FFFF_FFFF);

        // Backpressure in OUT; iv_load there must be ignored
        bus.m_axis_tready = 1'b0;
        push(64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        bad = 0;
        for (int i = 0; i < 200 && !bus.m_axis_tvalid; i++) @(negedge clk);
        iv = 64'h1234_5678_1234_5678;
        for (int i = 0; i < 10; i++) begin
            iv_load = (i == 3);
            if (!bus.m_axis_tvalid || bus.m_axis_tlast || bus.s_axis_tready ||
                bus.m_axis_tdata !== 64'hF0F0_F0F0_F0F0_F0F0) bad++;
            @(negedge clk);
        end
        iv_load = 1'b0;
        check_val("bp_stable", 64'(bad), 64'd0);
        check_val("bp_data", bus.m_axis_tdata, 64'hF0F0_F0F0_F0F0_F0F0);
        bus.m_axis_tready = 1'b1;
        @(negedge clk);
        check_val("bp_count", {32'd0, blk_count}, 64'd4);
        push(64'd0, 1'b0);
        pull(c0, l0);
        check_val("ivload_ignored", c0, 64'hF0F0_F0F0_F0F0_F0F0);

        // Message restart with tlast
        do_reset();
        iv      = 64'hDEAD_BEEF_CAFE_F00D;
        iv_load = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
        push(64'd0, 1'b1);
        pull(c0, l0);
        check_val("msg_c0", c0, 64'hDEAD_BEEF_CAFE_F00D);
        check_val("msg_last0", {63'd0, l0}, 64'd1);
        push(64'd0, 1'b1);
        pull(c1, l1);
        check_val("msg_c1", c1, 64'hDEAD_BEEF_CAFE_F00D);
        push(64'd1, 1'b1);
        pull(c2, l1);
        check_val("msg_c2", c2, 64'hDEAD_BEEF_CAFE_F00C);
        push(64'd0, 1'b0);
        pull(c2, l1);
`ifdef CBC_TLAST_REIV_EN
        ref_c = 64'hDEAD_BEEF_CAFE_F00D;
`else
        ref_c = 64'hDEAD_BEEF_CAFE_F00C;
`endif
        check_val("msg_restart", c2, ref_c);
        check_val("msg_last3", {63'd0, l1}, 64'd0);

        // Reset while the core holds the block
        push(64'h5A5A_5A5A_5A5A_5A5A, 1'b0);
        for (int i = 0; i < 200 && !bus.enc_s_axis_tready; i++) @(negedge clk);
        check_val("wait_reached", {63'd0, bus.enc_s_axis_tready}, 64'd1);
        rst = 1'b1;
        #1;
        check_val("rstw_enc_tready", {63'd0, bus.enc_s_axis_tready}, 64'd0);
        check_val("rstw_s_tready",   {63'd0, bus.s_axis_tready},     64'd0);
        check_val("rstw_m_tdata",    bus.m_axis_tdata,               64'd0);
        check_val("rstw_count",      {32'd0, blk_count},             64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid || bus.enc_m_axis_tvalid) bad++;
        end
        check_val("rstw_no_output", 64'(bad), 64'd0);
        push(64'h3C3C_3C3C_3C3C_3C3C, 1'b0);
        pull(c0, l0);
        check_val("rstw_c", c0, 64'h3C3C_3C3C_3C3C_3C3C);
        check_val("rstw_count1", {32'd0, blk_count}, 64'd1);

        // blk_count wrap
        force dut.r_blk_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_blk_count;
        @(negedge clk);
        check_val("wrap_pre", {32'd0, blk_count}, 64'h0000_0000_FFFF_FFFF);
        push(64'h0, 1'b0);
        pull(c0, l0);
        check_val("wrap_post", {32'd0, blk_count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
